// File: rtl/clock_time_keeper_pkg.sv
// Shared types and constants for the clock time keeper: FSM state encoding,
// field limits and the blinking colon mask.
package clock_time_keeper_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CFG_REQ,
    TIME_REQ,
    WAIT
  } state_t;

  localparam int unsigned HOURS_MAX   = 23;
  localparam int unsigned MINUTES_MAX = 59;
  localparam int unsigned SECONDS_MAX = 59;

  localparam logic [5:0] DP_COLON_MASK = 6'b001010;

endpackage

// File: rtl/clock_time_keeper_wrap_counter.sv
// Modulo counter: counts 0..MAX on inc, clears on clear (clear wins),
// and flags the wrapping increment on carry.
module wrap_counter #(
  parameter int unsigned MAX = 59,
  parameter int unsigned W   = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic         carry,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign carry = inc && (value == MAX_V);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc) begin
      value <= carry ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/clock_time_keeper.sv
// 24-hour timekeeper with set inputs; snapshots the time and schedules
// configuration/time writes to the display stage over stb/busy/ack.
module clock_time_keeper
  import clock_time_keeper_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 4095,
  parameter int unsigned TIMEOUT_W   = 12
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_1hz_stb,
  input  logic       i_set_stb,
  input  logic       i_set_hours,
  input  logic       i_set_minutes,
  input  logic       i_refresh_config,
  output logic       o_stb,
  output logic       o_write_config,
  input  logic       i_busy,
  input  logic       i_ack,
  output logic [4:0] o_hours,
  output logic [5:0] o_minutes,
  output logic [5:0] o_seconds,
  output logic [5:0] o_dp
);

  logic       run;
  logic       sec_inc, sec_clear, sec_carry;
  logic       min_inc, min_carry;
  logic       hr_inc, hr_carry;
  logic [5:0] sec, min;
  logic [4:0] hr;
  logic       change;

  // Ticks are frozen while either set level is held; set-minutes never carries into hours.
  assign run       = !i_set_hours && !i_set_minutes;
  assign sec_inc   = run && i_1hz_stb;
  assign sec_clear = i_set_stb && i_set_minutes;
  assign min_inc   = (run && sec_carry) || (i_set_stb && i_set_minutes);
  assign hr_inc    = (run && min_carry) || (i_set_stb && i_set_hours);
  assign change    = sec_inc || sec_clear || min_inc || hr_inc || hr_carry;

  wrap_counter #(.MAX(SECONDS_MAX), .W(6)) u_sec (
    .clk   (i_clk),
    .reset (i_reset),
    .inc   (sec_inc),
    .clear (sec_clear),
    .carry (sec_carry),
    .value (sec)
  );

  wrap_counter #(.MAX(MINUTES_MAX), .W(6)) u_min (
    .clk   (i_clk),
    .reset (i_reset),
    .inc   (min_inc),
    .clear (1'b0),
    .carry (min_carry),
    .value (min)
  );

  wrap_counter #(.MAX(HOURS_MAX), .W(5)) u_hr (
    .clk   (i_clk),
    .reset (i_reset),
    .inc   (hr_inc),
    .clear (1'b0),
    .carry (hr_carry),
    .value (hr)
  );

  state_t               state, next_state;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 timeout, abandon, enter_cfg, enter_time;
  logic                 dirty, cfg_pend, last_cfg;

  // wait_cnt is 0 in the first WAIT cycle, so ACK_TIMEOUT WAIT cycles elapse before giving up.
  assign timeout    = (wait_cnt == TIMEOUT_W'(ACK_TIMEOUT - 1));
  assign abandon    = (state == WAIT) && !i_ack && timeout;
  assign enter_cfg  = (state == IDLE) && (next_state == CFG_REQ);
  assign enter_time = (state == IDLE) && (next_state == TIME_REQ);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (!i_busy) begin
          if (cfg_pend) begin
            next_state = CFG_REQ;
          end else if (dirty) begin
            next_state = TIME_REQ;
          end
        end
      end
      CFG_REQ, TIME_REQ: next_state = WAIT;
      WAIT: begin
        if (i_ack || timeout) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_stb          = 1'b0;
    o_write_config = 1'b0;
    case (state)
      CFG_REQ: begin
        o_stb          = 1'b1;
        o_write_config = 1'b1;
      end
      TIME_REQ: o_stb = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cfg_pend  <= 1'b1;
      dirty     <= 1'b1;
      last_cfg  <= 1'b0;
      wait_cnt  <= '0;
      o_hours   <= '0;
      o_minutes <= '0;
      o_seconds <= '0;
      o_dp      <= '0;
    end else begin
      // New requests win over the clear on entry, so nothing arriving that cycle is lost.
      if (i_refresh_config || (abandon && last_cfg)) begin
        cfg_pend <= 1'b1;
      end else if (enter_cfg) begin
        cfg_pend <= 1'b0;
      end

      if (change || (abandon && !last_cfg)) begin
        dirty <= 1'b1;
      end else if (enter_time) begin
        dirty <= 1'b0;
      end

      if (enter_cfg) begin
        last_cfg <= 1'b1;
      end else if (enter_time) begin
        last_cfg <= 1'b0;
      end

      if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      if (enter_time) begin
        o_hours   <= hr;
        o_minutes <= min;
        o_seconds <= sec;
        o_dp      <= sec[0] ? '0 : DP_COLON_MASK;
      end
    end
  end

endmodule

// File: tb/tb_clock_time_keeper.sv
// Bench for clock_time_keeper: table-driven set/tick vectors, hand-written
// handshake corner cases and random stimulus against a time-of-day model.
module tb_clock_time_keeper;

  localparam int unsigned ACK_TO = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hz = 1'b0, set_stb = 1'b0, set_h = 1'b0, set_m = 1'b0, refresh = 1'b0;
  logic       busy = 1'b0, ack = 1'b0;
  logic       stb, wcfg;
  logic [4:0] hours;
  logic [5:0] minutes, seconds, dp;

  clock_time_keeper #(.ACK_TIMEOUT(ACK_TO), .TIMEOUT_W(4)) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_1hz_stb        (hz),
    .i_set_stb        (set_stb),
    .i_set_hours      (set_h),
    .i_set_minutes    (set_m),
    .i_refresh_config (refresh),
    .o_stb            (stb),
    .o_write_config   (wcfg),
    .i_busy           (busy),
    .i_ack            (ack),
    .o_hours          (hours),
    .o_minutes        (minutes),
    .o_seconds        (seconds),
    .o_dp             (dp)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  int mh = 0, mm = 0, ms = 0;        // model time of day
  int lh = 0, lm = 0, ls = 0;        // model time one edge back (what a snapshot captures)
  int esh = 0, esm = 0, ess = 0, exp_dp = 0;
  int stb_count = 0, last_stb_cyc = 0, stb_gap = 0;
  logic last_stb_cfg = 1'b0, prev_stb = 1'b0, time_written = 1'b0;
  logic obs_stb = 1'b0, obs_cfg = 1'b0;
  logic ack_on = 1'b1, ds_active = 1'b0;
  int ack_delay = 10, ds_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: observe outputs at the falling edge, run the downstream model, drive new inputs.
  task automatic step(input int t_hz, input int t_set, input int t_sh, input int t_sm, input int t_rc);
    int secs;
    @(negedge clk);
    cyc++;
    obs_stb = stb;
    obs_cfg = wcfg;
    if (reset) begin
      check("reset_stb", int'(stb), 0);
      check("reset_cfg", int'(wcfg), 0);
      check("reset_snap", int'({hours, minutes, seconds}), 0);
      check("reset_dp", int'(dp), 0);
      prev_stb = 1'b0; time_written = 1'b0; ds_active = 1'b0; busy = 1'b0; ack = 1'b0;
      esh = 0; esm = 0; ess = 0; exp_dp = 0;
    end else begin
      if (stb) begin
        check("stb_adjacent", int'(prev_stb), 0);
        stb_count++;
        stb_gap = cyc - last_stb_cyc;
        last_stb_cyc = cyc;
        last_stb_cfg = wcfg;
        if (!wcfg) begin
          esh = lh; esm = lm; ess = ls;
          exp_dp = (ls % 2 == 0) ? 10 : 0;
          time_written = 1'b1;
        end
      end
      check("snap_hours", int'(hours), esh);
      check("snap_minutes", int'(minutes), esm);
      check("snap_seconds", int'(seconds), ess);
      check("snap_dp", int'(dp), exp_dp);
      prev_stb = stb;
      ack = 1'b0;
      if (ds_active) begin
        ds_cnt--;
        if (ds_cnt == 0) begin
          ack = 1'b1; busy = 1'b0; ds_active = 1'b0;
        end
      end else if (stb && ack_on) begin
        ds_active = 1'b1; busy = 1'b1; ds_cnt = ack_delay;
      end
    end
    lh = mh; lm = mm; ls = ms;
    hz = (t_hz != 0); set_stb = (t_set != 0); set_h = (t_sh != 0); set_m = (t_sm != 0);
    refresh = (t_rc != 0);
    if (!reset) begin
      if (set_h || set_m) begin
        if (set_stb) begin
          if (set_m) begin mm = (mm + 1) % 60; ms = 0; end
          if (set_h) mh = (mh + 1) % 24;
        end
      end else if (hz) begin
        secs = ((mh * 3600 + mm * 60 + ms) + 1) % 86400;
        mh = secs / 3600; mm = (secs / 60) % 60; ms = secs % 60;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic wait_stb(input string name, input int target, input int bound);
    for (int i = 0; i < bound && stb_count < target; i++) step(0, 0, 0, 0, 0);
    check(name, stb_count, target);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mh = 0; mm = 0; ms = 0;
    idle(3);
    reset = 1'b0;
  endtask

  typedef struct {
    int sh, sm, st, tk, n;
    int eh, em, es;
  } vec_t;
  vec_t vecs[9];

  task automatic apply_row(input int r);
    for (int k = 0; k < vecs[r].n; k++) begin
      step(vecs[r].tk, vecs[r].st, vecs[r].sh, vecs[r].sm, 0);
      step(0, 0, vecs[r].sh, vecs[r].sm, 0);
    end
    idle(40);
    check("tbl_hours", int'(hours), vecs[r].eh);
    check("tbl_minutes", int'(minutes), vecs[r].em);
    check("tbl_seconds", int'(seconds), vecs[r].es);
  endtask

  initial begin
    int c0;
    int rsh, rsm;
    vecs[0] = '{sh: 1, sm: 0, st: 1, tk: 0, n: 23, eh: 23, em: 0,  es: 0};
    vecs[1] = '{sh: 0, sm: 1, st: 1, tk: 0, n: 59, eh: 23, em: 59, es: 0};
    vecs[2] = '{sh: 0, sm: 0, st: 0, tk: 1, n: 59, eh: 23, em: 59, es: 59};
    vecs[3] = '{sh: 1, sm: 0, st: 1, tk: 0, n: 13, eh: 13, em: 0,  es: 0};
    vecs[4] = '{sh: 0, sm: 1, st: 1, tk: 0, n: 59, eh: 13, em: 59, es: 0};
    vecs[5] = '{sh: 0, sm: 0, st: 0, tk: 1, n: 30, eh: 13, em: 59, es: 30};
    vecs[6] = '{sh: 0, sm: 1, st: 1, tk: 1, n: 61, eh: 13, em: 0,  es: 0};
    vecs[7] = '{sh: 1, sm: 1, st: 1, tk: 0, n: 1,  eh: 14, em: 1,  es: 0};
    vecs[8] = '{sh: 0, sm: 0, st: 0, tk: 1, n: 1,  eh: 14, em: 1,  es: 1};

    // Boot: configuration write first, then 00:00:00, then silence.
    ack_on = 1'b1; ack_delay = 10;
    do_reset();
    c0 = stb_count;
    step(0, 0, 0, 0, 0);
    check("boot_cfg_stb", int'(obs_stb), 1);
    check("boot_cfg_type", int'(obs_cfg), 1);
    wait_stb("boot_time_stb", c0 + 2, 40);
    check("boot_time_type", int'(last_stb_cfg), 0);
    idle(60);
    check("boot_no_extra_stb", stb_count, c0 + 2);

    ack_delay = 3;
    for (int r = 0; r < 3; r++) apply_row(r);

    // Wrap 23:59:59 -> 00:00:00: counter updates one edge, write issued the next.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("wrap_no_stb_yet", int'(obs_stb), 0);
    step(0, 0, 0, 0, 0);
    check("wrap_stb", int'(obs_stb), 1);
    check("wrap_type", int'(obs_cfg), 0);
    check("wrap_snapshot", int'({hours, minutes, seconds}), 0);
    check("wrap_dp", int'(dp), 10);
    idle(20);

    // From 00:00:00, row 3 brings hours to 13 before the minutes rows.
    for (int r = 3; r < 9; r++) apply_row(r);
    check("tbl_dp_odd", int'(dp), 0);

    // Three ticks while the downstream is busy: one follow-up write with the latest time.
    ack_delay = 12;
    idle(20);
    c0 = stb_count;
    step(1, 0, 0, 0, 0);
    wait_stb("busy_first_stb", c0 + 1, 10);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    end
    wait_stb("busy_followup_stb", c0 + 2, 40);
    idle(40);
    check("busy_single_followup", stb_count, c0 + 2);
    check("busy_latest_sec", int'(seconds), ms);

    // No ack: the same write type is re-requested after the timeout.
    ack_delay = 3;
    idle(20);
    ack_on = 1'b0;
    c0 = stb_count;
    step(1, 0, 0, 0, 0);
    wait_stb("to_time_stb", c0 + 1, 10);
    wait_stb("to_time_retry", c0 + 2, 30);
    check("to_time_gap", stb_gap, 17);
    check("to_time_retry_type", int'(last_stb_cfg), 0);
    ack_on = 1'b1;
    idle(40);
    ack_on = 1'b0;
    c0 = stb_count;
    step(0, 0, 0, 0, 1);
    wait_stb("to_cfg_stb", c0 + 1, 10);
    check("to_cfg_type", int'(last_stb_cfg), 1);
    wait_stb("to_cfg_retry", c0 + 2, 30);
    check("to_cfg_gap", stb_gap, 17);
    check("to_cfg_retry_type", int'(last_stb_cfg), 1);
    ack_on = 1'b1;
    idle(40);

    // Refresh and tick together: configuration goes first.
    c0 = stb_count;
    step(1, 0, 0, 0, 1);
    wait_stb("prio_first", c0 + 1, 10);
    check("prio_first_cfg", int'(last_stb_cfg), 1);
    wait_stb("prio_second", c0 + 2, 40);
    check("prio_second_time", int'(last_stb_cfg), 0);
    idle(30);

    // Reset in the middle of WAIT, then a clean boot.
    ack_on = 1'b0;
    c0 = stb_count;
    step(1, 0, 0, 0, 0);
    wait_stb("rst_wait_stb", c0 + 1, 10);
    idle(4);
    ack_on = 1'b1; ack_delay = 4;
    do_reset();
    step(0, 0, 0, 0, 0);
    check("rst_boot_cfg_stb", int'(obs_stb), 1);
    check("rst_boot_cfg_type", int'(obs_cfg), 1);
    idle(30);

    // Random traffic against the time-of-day model.
    rsh = 0; rsm = 0;
    for (int i = 0; i < 500; i++) begin
      ack_delay = int'($urandom_range(1, 8));
      if ($urandom_range(0, 24) == 0) rsh = 1 - rsh;
      if ($urandom_range(0, 24) == 0) rsm = 1 - rsm;
      step(($urandom_range(0, 99) < 30) ? 1 : 0, ($urandom_range(0, 99) < 15) ? 1 : 0,
           rsh, rsm, ($urandom_range(0, 99) < 3) ? 1 : 0);
    end
    idle(60);
    check("rand_final_hours", int'(hours), mh);
    check("rand_final_minutes", int'(minutes), mm);
    check("rand_final_seconds", int'(seconds), ms);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
